reset_key_ctrl: RTL and testbench

//   Front end for the soft-reset gate: turns a raw, bouncy push-button into a

---
 rtl/reset_key_ctrl.sv | 163 ++++++++++++++++
 tb/tb_reset_key_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_key_ctrl.sv
// Push-button front end for the soft-reset gate: sync, debounce, hold qualify, fire one pulse.
// Optional tap output enabled by defining RESET_KEY_SHORT_PRESS_EN.
module reset_key_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 100_000_000,
  parameter int PULSE_CYC    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_raw,
  input  logic i_en,
  output logic o_soft_rst,
  output logic o_key_db,
  output logic o_hold_active,
  output logic o_short_press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int PULSE_W = $clog2(PULSE_CYC + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYC);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESSED  = 2'd1,
    S_FIRE     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
  endfunction

  logic               r_key_p0;
  logic               r_key_p1;
  logic [DB_W-1:0]    r_db_cnt;
  logic               r_key_db;
  logic [DB_W-1:0]    w_db_cnt_nxt;
  logic               w_db_nxt;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_nxt;
  logic [PULSE_W-1:0] r_pulse_cnt;
  logic [PULSE_W-1:0] w_pulse_cnt_nxt;
  logic               r_soft_rst;
  logic               r_hold_active;

  // Stage p0/p1: two-flop synchroniser for the asynchronous key
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_p0 <= 1'b0;
      r_key_p1 <= 1'b0;
    end else begin
      r_key_p0 <= i_key_raw;
      r_key_p1 <= r_key_p0;
    end
  end

  // Debounce: the synced key must disagree with key_db for DEBOUNCE_CYC straight cycles
  always_comb begin
    w_db_nxt     = r_key_db;
    w_db_cnt_nxt = '0;
    if (r_key_p1 != r_key_db) begin
      if (r_db_cnt == DB_LAST) begin
        w_db_nxt = ~r_key_db;
      end else begin
        w_db_cnt_nxt = r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_key_db <= 1'b0;
    end else begin
      r_db_cnt <= w_db_cnt_nxt;
      r_key_db <= w_db_nxt;
    end
  end

  // The FSM looks at the next debounced level so PRESSED starts on the same edge key_db rises
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_pulse_cnt_nxt = r_pulse_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_db_nxt && !r_key_db) begin
          w_state_nxt    = S_PRESSED;
          w_hold_cnt_nxt = '0;
        end
      end
      S_PRESSED: begin
        w_hold_cnt_nxt = hold_sat_inc(r_hold_cnt);
        if (!w_db_nxt) begin
          w_state_nxt = S_IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt     = i_en ? S_FIRE : S_WAIT_REL;
          w_pulse_cnt_nxt = '0;
        end
      end
      S_FIRE: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_state_nxt = S_WAIT_REL;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + PULSE_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (!w_db_nxt) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hold_cnt    <= '0;
      r_pulse_cnt   <= '0;
      r_soft_rst    <= 1'b0;
      r_hold_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_pulse_cnt   <= w_pulse_cnt_nxt;
      r_soft_rst    <= (w_state_nxt == S_FIRE);
      r_hold_active <= (w_state_nxt == S_PRESSED);
    end
  end

  assign o_soft_rst    = r_soft_rst;
  assign o_key_db      = r_key_db;
  assign o_hold_active = r_hold_active;

`ifdef RESET_KEY_SHORT_PRESS_EN
  logic r_short_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_short_press <= 1'b0;
    end else begin
      r_short_press <= (r_state == S_PRESSED) && (w_state_nxt == S_IDLE);
    end
  end

  assign o_short_press = r_short_press;
`else
  assign o_short_press = 1'b0;
`endif

endmodule

// File: tb/tb_reset_key_ctrl.sv
// Directed scenarios plus random key/en/reset traffic for reset_key_ctrl,
// checked cycle by cycle against a timeline model of the key-to-pulse rules.
module tb_reset_key_ctrl;

  localparam int DB    = 4;
  localparam int HOLD  = 10;
  localparam int PULSE = 3;
`ifdef RESET_KEY_SHORT_PRESS_EN
  localparam int SP_EN = 1;
`else
  localparam int SP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic key_raw;
  logic en;
  logic soft_rst;
  logic key_db;
  logic hold_active;
  logic short_press;

  int errors = 0;
  int checks = 0;

  reset_key_ctrl #(
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC    (HOLD),
    .PULSE_CYC   (PULSE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_key_raw    (key_raw),
    .i_en         (en),
    .o_soft_rst   (soft_rst),
    .o_key_db     (key_db),
    .o_hold_active(hold_active),
    .o_short_press(short_press)
  );

  always #5 clk = ~clk;

  // Timeline model: raw key history, debounced level, and the cycle indices of
  // the current press and pulse.
  int n = 0;
  bit raw_d1 = 0, raw_d2 = 0;
  bit rst_d1 = 1, rst_d2 = 1;
  bit m_db = 0;
  int run = 0;
  int press_t = -1;
  int pulse_t = -1;
  bit waiting = 0;

  // Per-scenario observations of the DUT
  int w_soft_cyc, w_soft_rise, w_hold_cyc, w_short, w_db_hi;
  int t_db_first, t_soft_first;
  bit obs_soft_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic win_clear();
    w_soft_cyc = 0; w_soft_rise = 0; w_hold_cyc = 0; w_short = 0; w_db_hi = 0;
    t_db_first = -1; t_soft_first = -1;
  endtask

  task automatic step(input bit r_key, input bit r_en, input bit r_rst);
    bit sv, prev, e_short;
    key_raw = r_key;
    en      = r_en;
    rst     = r_rst;
    @(posedge clk);
    #1;
    e_short = 0;
    if (r_rst) begin
      m_db = 0; run = 0; press_t = -1; pulse_t = -1; waiting = 0;
    end else begin
      sv   = (rst_d1 || rst_d2) ? 1'b0 : raw_d2;
      prev = m_db;
      if (sv != m_db) begin
        run++;
        if (run == DB) begin
          m_db = ~m_db;
          run  = 0;
        end
      end else begin
        run = 0;
      end
      if (waiting) begin
        if (!m_db) waiting = 0;
      end else if (pulse_t >= 0) begin
        if (n - pulse_t >= PULSE) begin
          pulse_t = -1;
          waiting = 1;
        end
      end else if (press_t >= 0) begin
        if (!m_db) begin
          press_t = -1;
          e_short = (SP_EN != 0);
        end else if (n - press_t == HOLD) begin
          press_t = -1;
          if (r_en) pulse_t = n;
          else      waiting = 1;
        end
      end else if (m_db && !prev) begin
        press_t = n;
      end
    end
    raw_d2 = raw_d1; raw_d1 = r_key;
    rst_d2 = rst_d1; rst_d1 = r_rst;

    chk("key_db",      {31'd0, key_db},      {31'd0, m_db});
    chk("soft_rst",    {31'd0, soft_rst},    {31'd0, pulse_t >= 0});
    chk("hold_active", {31'd0, hold_active}, {31'd0, press_t >= 0});
    chk("short_press", {31'd0, short_press}, {31'd0, e_short});

    if (soft_rst === 1'b1) begin
      w_soft_cyc++;
      if (!obs_soft_prev) w_soft_rise++;
      if (t_soft_first < 0) t_soft_first = n;
    end
    if (hold_active === 1'b1) w_hold_cyc++;
    if (short_press === 1'b1) w_short++;
    if (key_db === 1'b1) begin
      w_db_hi++;
      if (t_db_first < 0) t_db_first = n;
    end
    obs_soft_prev = (soft_rst === 1'b1);
    n++;
    @(negedge clk);
  endtask

  initial begin
    int t_key;
    bit seen;
    bit rk;
    int len;
    key_raw = 0; en = 0; rst = 1;
    win_clear();
    @(negedge clk);

    // Reset state
    step(0, 0, 1);
    chk("rst_soft_rst",    {31'd0, soft_rst},    32'd0);
    chk("rst_key_db",      {31'd0, key_db},      32'd0);
    chk("rst_hold_active", {31'd0, hold_active}, 32'd0);
    chk("rst_short_press", {31'd0, short_press}, 32'd0);
    step(0, 0, 1);
    repeat (5) step(0, 1, 0);

    // 1: one-cycle bounces never reach key_db
    win_clear();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
    repeat (20) step(0, 1, 0);
    chk("t1_db_high_cycles", w_db_hi, 0);
    chk("t1_soft_cycles",    w_soft_cyc, 0);

    // 2: long press with en=1
    win_clear();
    t_key = n;
    repeat (30) step(1, 1, 0);
    chk("t2_db_latency",   t_db_first - t_key + 1, DB + 2);
    chk("t2_fire_latency", t_soft_first - t_db_first, HOLD);
    chk("t2_soft_cycles",  w_soft_cyc, PULSE);
    chk("t2_hold_cycles",  w_hold_cyc, HOLD);
    repeat (20) step(0, 1, 0);

    // 3: long press with en=0 parks in the release wait
    win_clear();
    repeat (30) step(1, 0, 0);
    chk("t3_held_db",      {31'd0, key_db},      32'd1);
    chk("t3_held_hold",    {31'd0, hold_active}, 32'd0);
    chk("t3_soft_cycles",  w_soft_cyc, 0);
    chk("t3_hold_cycles",  w_hold_cyc, HOLD);
    repeat (20) step(0, 0, 0);
    chk("t3_released_db",  {31'd0, key_db}, 32'd0);

    // 4: short tap
    win_clear();
    repeat (8) step(1, 1, 0);
    repeat (20) step(0, 1, 0);
    chk("t4_soft_cycles", w_soft_cyc, 0);
    chk("t4_short_count", w_short, SP_EN);

    // 5: reset during the second pulse cycle, then a fresh press
    win_clear();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1, 1, 0);
      seen = (soft_rst === 1'b1);
    end
    chk("t5_pulse_seen", {31'd0, seen}, 32'd1);
    step(1, 1, 0);
    chk("t5_second_cycle", {31'd0, soft_rst}, 32'd1);
    step(1, 1, 1);
    chk("t5_rst_soft",  {31'd0, soft_rst},    32'd0);
    chk("t5_rst_db",    {31'd0, key_db},      32'd0);
    chk("t5_rst_hold",  {31'd0, hold_active}, 32'd0);
    win_clear();
    repeat (40) step(1, 1, 0);
    chk("t5_new_pulses",      w_soft_rise, 1);
    chk("t5_new_soft_cycles", w_soft_cyc, PULSE);
    repeat (20) step(0, 1, 0);

    // 6: very long hold fires exactly once
    win_clear();
    repeat (100) step(1, 1, 0);
    chk("t6_pulses",      w_soft_rise, 1);
    chk("t6_soft_cycles", w_soft_cyc, PULSE);
    chk("t6_hold_cycles", w_hold_cyc, HOLD);
    repeat (20) step(0, 1, 0);

    // Random key segments with random en and rare resets
    for (int s = 0; s < 200; s++) begin
      rk  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        step(rk, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
